model_vector_summation_arbiter: RTL and testbench

Shares one `model_vector_summation` engine between `REQUESTERS` clients, such as NTM read/write heads, that each need a vector summation. A round-robin arbiter grants the engine to one client at a time. While a client holds the grant, the block routes that client's size, length, data and enables into the engine and returns the engine's results and handshakes to that client only. Requests with a zero dimension are rejected without starting the engine.

---
 rtl/model_ntm_arbiter_pkg.sv | 24 ++
 rtl/model_vector_summation.sv | 142 ++++++++++++++
 rtl/model_vector_summation_arbiter.sv | 160 ++++++++++++++++
 tb/tb_model_vector_summation_arbiter.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/model_ntm_arbiter_pkg.sv
// Shared types and constants for the NTM vector-summation arbiter and its engine.
package model_ntm_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE_STATE   = 2'd0,
    START_STATE  = 2'd1,
    STREAM_STATE = 2'd2,
    REJECT_STATE = 2'd3
  } arbiter_state_t;

  typedef enum logic [1:0] {
    ENGINE_IDLE       = 2'd0,
    ENGINE_ACCUMULATE = 2'd1,
    ENGINE_OUTPUT     = 2'd2
  } engine_state_t;

  // Control fields are at most 64 bits wide; users slice these to CONTROL_SIZE.
  localparam logic [63:0] ZERO_CONTROL = 64'd0;
  localparam logic [63:0] ONE_CONTROL  = 64'd1;

  // Accumulator entries in the engine; vector SIZE must not exceed this.
  localparam int ENGINE_DEPTH = 16;

endpackage

// File: rtl/model_vector_summation.sv
// Vector summation engine: sums LENGTH vectors of SIZE words element-wise,
// words arrive length-major, results stream out one element per cycle.
module model_vector_summation
  import model_ntm_arbiter_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    START,
  output logic                    READY,
  input  logic                    DATA_IN_VECTOR_ENABLE,
  input  logic                    DATA_IN_SCALAR_ENABLE,
  output logic                    DATA_OUT_VECTOR_ENABLE,
  output logic                    DATA_OUT_SCALAR_ENABLE,
  input  logic [CONTROL_SIZE-1:0] SIZE_IN,
  input  logic [CONTROL_SIZE-1:0] LENGTH_IN,
  input  logic [DATA_SIZE-1:0]    DATA_IN,
  output logic [DATA_SIZE-1:0]    DATA_OUT
);

  localparam int ADDR_SIZE = $clog2(ENGINE_DEPTH);
  localparam logic [CONTROL_SIZE-1:0] ZERO = ZERO_CONTROL[CONTROL_SIZE-1:0];
  localparam logic [CONTROL_SIZE-1:0] ONE  = ONE_CONTROL[CONTROL_SIZE-1:0];

  engine_state_t state_reg, state_next;
  logic [CONTROL_SIZE-1:0] size_reg, size_next, length_reg, length_next;
  logic [CONTROL_SIZE-1:0] column_reg, column_next, row_reg, row_next;
  logic [CONTROL_SIZE-1:0] out_index_reg, out_index_next;
  logic [DATA_SIZE-1:0]    data_out_reg, data_out_next;
  logic                    ready_reg, ready_next;
  logic                    vector_out_reg, vector_out_next;
  logic                    scalar_out_reg, scalar_out_next;

  logic [DATA_SIZE-1:0]    acc_mem [ENGINE_DEPTH];

  logic [CONTROL_SIZE-1:0] eff_size, eff_length, eff_column, eff_row;
  logic                    accept, last_column, last_row;
  logic [ADDR_SIZE-1:0]    write_addr, read_addr;

  // A word strobed in the START cycle itself counts as the first element.
  assign eff_size   = (state_reg == ENGINE_IDLE) ? SIZE_IN   : size_reg;
  assign eff_length = (state_reg == ENGINE_IDLE) ? LENGTH_IN : length_reg;
  assign eff_column = (state_reg == ENGINE_IDLE) ? ZERO      : column_reg;
  assign eff_row    = (state_reg == ENGINE_IDLE) ? ZERO      : row_reg;

  assign accept = (DATA_IN_VECTOR_ENABLE | DATA_IN_SCALAR_ENABLE) &
                  ((state_reg == ENGINE_ACCUMULATE) | ((state_reg == ENGINE_IDLE) & START));
  assign last_column = (eff_column == eff_size - ONE);
  assign last_row    = (eff_row == eff_length - ONE);
  assign write_addr  = eff_column[ADDR_SIZE-1:0];
  assign read_addr   = out_index_reg[ADDR_SIZE-1:0];

  always_ff @(posedge CLK) begin
    if (accept) begin
      acc_mem[write_addr] <= (eff_row == ZERO) ? DATA_IN : acc_mem[write_addr] + DATA_IN;
    end
  end

  always_comb begin
    state_next      = state_reg;
    size_next       = size_reg;
    length_next     = length_reg;
    column_next     = column_reg;
    row_next        = row_reg;
    out_index_next  = out_index_reg;
    data_out_next   = data_out_reg;
    ready_next      = 1'b0;
    vector_out_next = 1'b0;
    scalar_out_next = 1'b0;
    case (state_reg)
      ENGINE_IDLE: begin
        if (START) begin
          state_next  = ENGINE_ACCUMULATE;
          size_next   = SIZE_IN;
          length_next = LENGTH_IN;
          column_next = ZERO;
          row_next    = ZERO;
        end
      end
      ENGINE_OUTPUT: begin
        data_out_next   = acc_mem[read_addr];
        scalar_out_next = 1'b1;
        if (out_index_reg == size_reg - ONE) begin
          vector_out_next = 1'b1;
          ready_next      = 1'b1;
          state_next      = ENGINE_IDLE;
        end else begin
          out_index_next = out_index_reg + ONE;
        end
      end
      default: ;
    endcase
    if (accept) begin
      if (last_column) begin
        column_next = ZERO;
        if (last_row) begin
          state_next     = ENGINE_OUTPUT;
          out_index_next = ZERO;
        end else begin
          row_next = eff_row + ONE;
        end
      end else begin
        column_next = eff_column + ONE;
        row_next    = eff_row;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg      <= ENGINE_IDLE;
      size_reg       <= '0;
      length_reg     <= '0;
      column_reg     <= '0;
      row_reg        <= '0;
      out_index_reg  <= '0;
      data_out_reg   <= '0;
      ready_reg      <= 1'b0;
      vector_out_reg <= 1'b0;
      scalar_out_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      size_reg       <= size_next;
      length_reg     <= length_next;
      column_reg     <= column_next;
      row_reg        <= row_next;
      out_index_reg  <= out_index_next;
      data_out_reg   <= data_out_next;
      ready_reg      <= ready_next;
      vector_out_reg <= vector_out_next;
      scalar_out_reg <= scalar_out_next;
    end
  end

  assign READY                  = ready_reg;
  assign DATA_OUT               = data_out_reg;
  assign DATA_OUT_VECTOR_ENABLE = vector_out_reg;
  assign DATA_OUT_SCALAR_ENABLE = scalar_out_reg;

endmodule

// File: rtl/model_vector_summation_arbiter.sv
// Round-robin arbiter sharing one vector summation engine between several
// clients; zero-dimension requests are rejected without starting the engine.
module model_vector_summation_arbiter
  import model_ntm_arbiter_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int REQUESTERS   = 4,
  parameter int IDX_SIZE     = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1
) (
  input  logic                               CLK,
  input  logic                               RST,
  input  logic [REQUESTERS-1:0]              REQ,
  output logic [REQUESTERS-1:0]              GRANT,
  output logic [IDX_SIZE-1:0]                GRANT_INDEX,
  output logic                               BUSY,
  input  logic [REQUESTERS*CONTROL_SIZE-1:0] SIZE_IN,
  input  logic [REQUESTERS*CONTROL_SIZE-1:0] LENGTH_IN,
  input  logic [REQUESTERS*DATA_SIZE-1:0]    DATA_IN,
  input  logic [REQUESTERS-1:0]              DATA_IN_VECTOR_ENABLE,
  input  logic [REQUESTERS-1:0]              DATA_IN_SCALAR_ENABLE,
  output logic [REQUESTERS-1:0]              READY,
  output logic [REQUESTERS-1:0]              ERROR,
  output logic [REQUESTERS-1:0]              DATA_OUT_VECTOR_ENABLE,
  output logic [REQUESTERS-1:0]              DATA_OUT_SCALAR_ENABLE,
  output logic [DATA_SIZE-1:0]               DATA_OUT
);

  localparam logic [CONTROL_SIZE-1:0] ZERO = ZERO_CONTROL[CONTROL_SIZE-1:0];

  // First set request at or above the pointer, wrapping around.
  function automatic logic [IDX_SIZE-1:0] rr_pick(input logic [REQUESTERS-1:0] req,
                                                  input logic [IDX_SIZE-1:0]   ptr);
    logic                found;
    logic [IDX_SIZE-1:0] cand_index;
    int                  cand;
    rr_pick = '0;
    found   = 1'b0;
    for (int k = 0; k < REQUESTERS; k++) begin
      cand       = (int'(ptr) + k) % REQUESTERS;
      cand_index = IDX_SIZE'(cand);
      if (!found && req[cand_index]) begin
        found   = 1'b1;
        rr_pick = cand_index;
      end
    end
  endfunction

  arbiter_state_t          state_reg, state_next;
  logic [REQUESTERS-1:0]   grant_reg, grant_next;
  logic [IDX_SIZE-1:0]     grant_index_reg, grant_index_next;
  logic [IDX_SIZE-1:0]     rr_pointer_reg, rr_pointer_next;
  logic [IDX_SIZE-1:0]     pick, index_after;

  logic [CONTROL_SIZE-1:0] size_array   [REQUESTERS];
  logic [CONTROL_SIZE-1:0] length_array [REQUESTERS];
  logic [DATA_SIZE-1:0]    data_array   [REQUESTERS];

  logic                    engine_start, engine_ready;
  logic                    engine_vector_in, engine_scalar_in;
  logic                    engine_vector_out, engine_scalar_out;
  logic                    streaming, rejecting;

  generate
    for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_unpack
      assign size_array[gi]   = SIZE_IN[gi*CONTROL_SIZE +: CONTROL_SIZE];
      assign length_array[gi] = LENGTH_IN[gi*CONTROL_SIZE +: CONTROL_SIZE];
      assign data_array[gi]   = DATA_IN[gi*DATA_SIZE +: DATA_SIZE];
    end
  endgenerate

  assign pick        = rr_pick(REQ, rr_pointer_reg);
  assign index_after = (grant_index_reg == IDX_SIZE'(REQUESTERS - 1)) ? '0
                                                                      : grant_index_reg + 1'b1;

  always_comb begin
    state_next       = state_reg;
    grant_next       = grant_reg;
    grant_index_next = grant_index_reg;
    rr_pointer_next  = rr_pointer_reg;
    case (state_reg)
      IDLE_STATE: begin
        if (|REQ) begin
          grant_next       = '0;
          grant_next[pick] = 1'b1;
          grant_index_next = pick;
          if ((size_array[pick] == ZERO) || (length_array[pick] == ZERO)) begin
            state_next = REJECT_STATE;
          end else begin
            state_next = START_STATE;
          end
        end
      end
      START_STATE: state_next = STREAM_STATE;
      STREAM_STATE: begin
        if (engine_ready) begin
          state_next      = IDLE_STATE;
          grant_next      = '0;
          rr_pointer_next = index_after;
        end
      end
      REJECT_STATE: begin
        state_next      = IDLE_STATE;
        grant_next      = '0;
        rr_pointer_next = index_after;
      end
      default: state_next = IDLE_STATE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg       <= IDLE_STATE;
      grant_reg       <= '0;
      grant_index_reg <= '0;
      rr_pointer_reg  <= '0;
    end else begin
      state_reg       <= state_next;
      grant_reg       <= grant_next;
      grant_index_reg <= grant_index_next;
      rr_pointer_reg  <= rr_pointer_next;
    end
  end

  assign streaming    = (state_reg == STREAM_STATE);
  assign rejecting    = (state_reg == REJECT_STATE);
  assign engine_start = (state_reg == START_STATE);

  // Only the granted client's strobes reach the engine.
  assign engine_vector_in = DATA_IN_VECTOR_ENABLE[grant_index_reg] & grant_reg[grant_index_reg];
  assign engine_scalar_in = DATA_IN_SCALAR_ENABLE[grant_index_reg] & grant_reg[grant_index_reg];

  model_vector_summation #(
    .DATA_SIZE    (DATA_SIZE),
    .CONTROL_SIZE (CONTROL_SIZE)
  ) engine (
    .CLK                    (CLK),
    .RST                    (RST),
    .START                  (engine_start),
    .READY                  (engine_ready),
    .DATA_IN_VECTOR_ENABLE  (engine_vector_in),
    .DATA_IN_SCALAR_ENABLE  (engine_scalar_in),
    .DATA_OUT_VECTOR_ENABLE (engine_vector_out),
    .DATA_OUT_SCALAR_ENABLE (engine_scalar_out),
    .SIZE_IN                (size_array[grant_index_reg]),
    .LENGTH_IN              (length_array[grant_index_reg]),
    .DATA_IN                (data_array[grant_index_reg]),
    .DATA_OUT               (DATA_OUT)
  );

  assign GRANT                  = grant_reg;
  assign GRANT_INDEX            = grant_index_reg;
  assign BUSY                   = (state_reg != IDLE_STATE);
  assign READY                  = ({REQUESTERS{engine_ready & streaming}} & grant_reg) |
                                  ({REQUESTERS{rejecting}} & grant_reg);
  assign ERROR                  = {REQUESTERS{rejecting}} & grant_reg;
  assign DATA_OUT_VECTOR_ENABLE = {REQUESTERS{engine_vector_out}} & grant_reg;
  assign DATA_OUT_SCALAR_ENABLE = {REQUESTERS{engine_scalar_out}} & grant_reg;

endmodule

// File: tb/tb_model_vector_summation_arbiter.sv
// Scoreboard bench for the summation arbiter: expected element sums are queued
// when a client streams its data and popped as the engine emits results.
module tb_model_vector_summation_arbiter;

  localparam int DW = 64;
  localparam int CW = 64;
  localparam int RQ = 4;
  localparam int IW = 2;

  logic           clk, rst;
  logic [RQ-1:0]  req;
  logic [RQ-1:0]  grant, ready, error, out_vec_en, out_sca_en;
  logic [IW-1:0]  grant_index;
  logic           busy;
  logic [RQ*CW-1:0] size_in, length_in;
  logic [RQ*DW-1:0] data_in;
  logic [RQ-1:0]  vec_en, sca_en;
  logic [DW-1:0]  data_out;

  logic [63:0] size_cfg [RQ];
  logic [63:0] len_cfg  [RQ];
  logic [63:0] base_cfg [RQ];
  logic [63:0] data_word[RQ];

  typedef struct {
    int          client;
    logic [63:0] value;
  } sb_entry_t;
  sb_entry_t sb_q[$];

  int checks_count = 0;
  int errors_count = 0;
  int start_total  = 0;

  model_vector_summation_arbiter #(
    .DATA_SIZE(DW), .CONTROL_SIZE(CW), .REQUESTERS(RQ), .IDX_SIZE(IW)
  ) dut (
    .CLK(clk), .RST(rst), .REQ(req), .GRANT(grant), .GRANT_INDEX(grant_index),
    .BUSY(busy), .SIZE_IN(size_in), .LENGTH_IN(length_in), .DATA_IN(data_in),
    .DATA_IN_VECTOR_ENABLE(vec_en), .DATA_IN_SCALAR_ENABLE(sca_en),
    .READY(ready), .ERROR(error), .DATA_OUT_VECTOR_ENABLE(out_vec_en),
    .DATA_OUT_SCALAR_ENABLE(out_sca_en), .DATA_OUT(data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    for (int i = 0; i < RQ; i++) begin
      size_in[i*CW +: CW]   = size_cfg[i];
      length_in[i*CW +: CW] = len_cfg[i];
      data_in[i*DW +: DW]   = data_word[i];
    end
  end

  task automatic check_value(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks_count++;
    if (observed !== expected) begin
      errors_count++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // Result monitor: every output strobe must belong to the granted client
  // and match the next queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (dut.engine_start) start_total++;
      for (int i = 0; i < RQ; i++) begin
        if (out_sca_en[i]) begin
          check_value("out_en_granted", 64'(grant[i]), 64'd1);
          if (sb_q.size() == 0) begin
            check_value("sb_unexpected", 64'(i), 64'hFFFF);
          end else begin
            sb_entry_t e;
            e = sb_q.pop_front();
            check_value("sb_client", 64'(i), 64'(e.client));
            check_value("sb_data", data_out, e.value);
          end
        end
        if (out_vec_en[i]) check_value("vec_en_granted", 64'(grant[i]), 64'd1);
      end
    end
  end

  task automatic run_transfer(input int exp_client, input int exp_wait,
                              input logic [3:0] drop_mask, input bit leak,
                              input bit expect_reject);
    int          waited;
    int          sz, len;
    logic [63:0] acc, last_sum;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (grant == '0 && waited < 40);
    if (grant == '0) begin
      check_value("grant_timeout", 64'd0, 64'd1);
      return;
    end
    if (exp_wait != 0) check_value("grant_latency", 64'(waited), 64'(exp_wait));
    check_value("grant", 64'(grant), 64'd1 << exp_client);
    check_value("busy", 64'(busy), 64'd1);
    check_value("grant_index", 64'(grant_index), 64'(exp_client));
    if (expect_reject) begin
      check_value("reject_ready", 64'(ready), 64'd1 << exp_client);
      check_value("reject_error", 64'(error), 64'd1 << exp_client);
      check_value("reject_no_start", 64'(dut.engine_start), 64'd0);
      req = req & ~drop_mask;
      @(negedge clk);
      check_value("reject_ready_clear", 64'(ready | error), 64'd0);
      check_value("reject_grant_clear", 64'(grant), 64'd0);
      $display("transfer client %0d rejected", exp_client);
      return;
    end
    check_value("ready_early", 64'(ready), 64'd0);
    check_value("start_pulse", 64'(dut.engine_start), 64'd1);
    sz = int'(size_cfg[exp_client]);
    len = int'(len_cfg[exp_client]);
    last_sum = '0;
    for (int j = 0; j < sz; j++) begin
      acc = '0;
      for (int l = 0; l < len; l++) acc += base_cfg[exp_client] + 64'(l * sz + j);
      sb_q.push_back('{client: exp_client, value: acc});
      last_sum = acc;
    end
    for (int k = 0; k < sz * len; k++) begin
      @(posedge clk); #1;
      data_word[exp_client] = base_cfg[exp_client] + 64'(k);
      sca_en[exp_client] = 1'b1;
      if (leak) begin
        data_word[2] = 64'd1000;
        vec_en[2]    = 1'b1;
      end
      if (k == 0) begin
        @(negedge clk);
        check_value("start_one_cycle", 64'(dut.engine_start), 64'd0);
      end
    end
    @(posedge clk); #1;
    sca_en[exp_client] = 1'b0;
    vec_en[2] = 1'b0;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (!ready[exp_client] && waited < 100);
    if (!ready[exp_client]) begin
      check_value("ready_timeout", 64'd0, 64'd1);
      return;
    end
    check_value("ready_onehot", 64'(ready), 64'd1 << exp_client);
    check_value("error_on_ok", 64'(error), 64'd0);
    check_value("result", data_out, last_sum);
    req = req & ~drop_mask;
    @(negedge clk);
    check_value("grant_released", 64'(grant), 64'd0);
    check_value("busy_released", 64'(busy), 64'd0);
    check_value("ready_pulse", 64'(ready), 64'd0);
    $display("transfer client %0d size %0d length %0d result %0d", exp_client, sz, len, last_sum);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int waited;
    rst = 1'b1;
    req = '0;
    vec_en = '0;
    sca_en = '0;
    for (int i = 0; i < RQ; i++) begin
      data_word[i] = '0;
      base_cfg[i]  = 64'(1 + 10 * i);
    end
    size_cfg[0] = 2; len_cfg[0] = 2;
    size_cfg[1] = 3; len_cfg[1] = 2;
    size_cfg[2] = 2; len_cfg[2] = 3;
    size_cfg[3] = 1; len_cfg[3] = 0;

    repeat (2) @(negedge clk);
    check_value("rst_grant", 64'(grant), 64'd0);
    check_value("rst_index", 64'(grant_index), 64'd0);
    check_value("rst_busy", 64'(busy), 64'd0);
    check_value("rst_ready_error", 64'(ready | error), 64'd0);
    check_value("rst_out_en", 64'(out_vec_en | out_sca_en), 64'd0);
    check_value("rst_data_out", data_out, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single request: words 1,2,3,4 sum element-wise to 4 and 6.
    @(posedge clk); #1;
    req = 4'b0001;
    run_transfer(0, 2, 4'b0001, 1'b0, 1'b0);

    // Isolation: client 2 strobes while client 1 holds the engine.
    @(posedge clk); #1;
    req = 4'b0110;
    run_transfer(1, 2, 4'b0110, 1'b1, 1'b0);

    // Reject on zero length; pointer advances past client 3 to 0.
    @(posedge clk); #1;
    req = 4'b1000;
    run_transfer(3, 2, 4'b1000, 1'b0, 1'b1);

    // Pointer wrap: client 0 wins over client 3, then client 3 is served.
    len_cfg[3] = 3;
    @(posedge clk); #1;
    req = 4'b1001;
    run_transfer(0, 2, 4'b0001, 1'b0, 1'b0);
    run_transfer(3, 1, 4'b1000, 1'b0, 1'b0);

    // Contention: all requests held, one idle cycle between grants.
    @(posedge clk); #1;
    req = 4'b1111;
    run_transfer(0, 2, 4'b0000, 1'b0, 1'b0);
    run_transfer(1, 1, 4'b0000, 1'b0, 1'b0);
    run_transfer(2, 1, 4'b0000, 1'b0, 1'b0);
    run_transfer(3, 1, 4'b0000, 1'b0, 1'b0);
    run_transfer(0, 1, 4'b1111, 1'b0, 1'b0);

    // Reset in the middle of a stream aborts everything at once.
    @(posedge clk); #1;
    req = 4'b0100;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (grant == '0 && waited < 40);
    check_value("midrst_grant", 64'(grant), 64'd4);
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      data_word[2] = base_cfg[2] + 64'(k);
      sca_en[2] = 1'b1;
    end
    @(posedge clk); #1;
    sca_en[2] = 1'b0;
    rst = 1'b1;
    #1;
    check_value("midrst_grant_clear", 64'(grant), 64'd0);
    check_value("midrst_index", 64'(grant_index), 64'd0);
    check_value("midrst_busy", 64'(busy), 64'd0);
    check_value("midrst_ready_error", 64'(ready | error), 64'd0);
    check_value("midrst_out_en", 64'(out_vec_en | out_sca_en), 64'd0);
    check_value("midrst_data_out", data_out, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    $display("transfer client 2 aborted by reset");
    run_transfer(2, 2, 4'b0100, 1'b0, 1'b0);

    repeat (3) @(negedge clk);
    check_value("sb_drained", 64'(sb_q.size()), 64'd0);
    check_value("start_total", 64'(start_total), 64'd11);
    $display("CHECKS %0d ERRORS %0d", checks_count, errors_count);
    $finish;
  end

endmodule
